// File: rtl/array_multiplier.sv
// Unsigned 8x8 carry-save array multiplier with a ripple-carry final row and a registered 16-bit product.
// Define ARRAY_MULT_PIPE_EN to register the array after carry-save row 4 (latency 2 instead of 1).
module array_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_valid,
  output logic [15:0] sum,
  output logic        out_valid
);

  // One carry-save row of full-adder cells; returns {carry, sum}.
  // The previous row's sum is shifted down one bit so each cell sees operands of equal weight.
  function automatic logic [15:0] csa_row(input logic [7:0] pp, input logic [7:0] s_prev,
                                          input logic [7:0] c_prev);
    logic [7:0] s_in;
    s_in = s_prev >> 1;
    return {(pp & s_in) | (pp & c_prev) | (s_in & c_prev), pp ^ s_in ^ c_prev};
  endfunction

  logic [7:0]  w_s4;
  logic [7:0]  w_c4;
  logic [4:0]  w_lo4;

  logic [7:0]  w_b_s4;
  logic [7:0]  w_b_c4;
  logic [4:0]  w_b_lo;
  logic [7:0]  w_b_a;
  logic [2:0]  w_b_bhi;
  logic        w_b_v;

  logic [15:0] w_product;

  // Row 0 plus carry-save rows 1..4
  always_comb begin : stage_a
    logic [7:0] v_s;
    logic [7:0] v_c;
    v_s   = a & {8{b[0]}};
    v_c   = '0;
    w_lo4 = '0;
    w_lo4[0] = v_s[0];
    for (int unsigned i = 1; i < 5; i++) begin
      {v_c, v_s} = csa_row(a & {8{b[i]}}, v_s, v_c);
      w_lo4[i]   = v_s[0];
    end
    w_s4 = v_s;
    w_c4 = v_c;
  end

`ifdef ARRAY_MULT_PIPE_EN
  logic [7:0] r_s4;
  logic [7:0] r_c4;
  logic [4:0] r_lo4;
  logic [7:0] r_a;
  logic [2:0] r_bhi;
  logic       r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s4  <= '0;
      r_c4  <= '0;
      r_lo4 <= '0;
      r_a   <= '0;
      r_bhi <= '0;
      r_v   <= 1'b0;
    end else begin
      r_s4  <= w_s4;
      r_c4  <= w_c4;
      r_lo4 <= w_lo4;
      r_a   <= a;
      r_bhi <= b[7:5];
      r_v   <= in_valid;
    end
  end

  assign w_b_s4  = r_s4;
  assign w_b_c4  = r_c4;
  assign w_b_lo  = r_lo4;
  assign w_b_a   = r_a;
  assign w_b_bhi = r_bhi;
  assign w_b_v   = r_v;
`else
  assign w_b_s4  = w_s4;
  assign w_b_c4  = w_c4;
  assign w_b_lo  = w_lo4;
  assign w_b_a   = a;
  assign w_b_bhi = b[7:5];
  assign w_b_v   = in_valid;
`endif

  // Carry-save rows 5..7, then the 8-bit ripple row producing product[15:8]
  always_comb begin : stage_b
    logic [7:0] v_s;
    logic [7:0] v_c;
    logic [7:0] v_lo;
    logic [7:0] v_hi;
    logic [7:0] v_x;
    logic       v_cy;
    v_s  = w_b_s4;
    v_c  = w_b_c4;
    v_lo = {3'b000, w_b_lo};
    v_hi = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      {v_c, v_s}  = csa_row(w_b_a & {8{w_b_bhi[k]}}, v_s, v_c);
      v_lo[5 + k] = v_s[0];
    end
    v_x  = v_s >> 1;
    v_cy = 1'b0;
    for (int unsigned j = 0; j < 8; j++) begin
      v_hi[j] = v_x[j] ^ v_c[j] ^ v_cy;
      v_cy    = (v_x[j] & v_c[j]) | (v_cy & (v_x[j] ^ v_c[j]));
    end
    w_product = {v_hi, v_lo};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_b_v;
      if (w_b_v) begin
        sum <= w_product;
      end
    end
  end

endmodule

// File: tb/tb_array_multiplier.sv
// Directed and exhaustive checks of array_multiplier; honours ARRAY_MULT_PIPE_EN for latency.
module tb_array_multiplier;

`ifdef ARRAY_MULT_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_valid;
  logic [15:0] sum;
  logic        out_valid;

  array_multiplier u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        v;
    logic [15:0] s;
  } exp_t;

  exp_t        q[$];
  logic [15:0] held;
  int          n_tests;
  int          n_fail;
  vec_t        vecs[8];

  task automatic check(input string name, input logic exp_v, input logic [15:0] exp_s);
    n_tests++;
    if (out_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s: out_valid=%0b required %0b", name, out_valid, exp_v);
    end
    n_tests++;
    if (sum !== exp_s) begin
      n_fail++;
      $display("FAIL %s: sum=0x%04h required 0x%04h", name, sum, exp_s);
    end
  endtask

  // Apply one cycle of stimulus, then check the outputs #1 after the edge.
  task automatic step(input string name, input logic r, input logic v,
                      input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    exp_t ent;
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      held = '0;
      check(name, 1'b0, 16'h0000);
    end else begin
      ent.v = v;
      ent.s = e;
      q.push_back(ent);
      if (q.size() == LAT) begin
        ent = q.pop_front();
        if (ent.v) held = ent.s;
        check(name, ent.v, held);
      end else begin
        check(name, 1'b0, held);
      end
    end
  endtask

  task automatic flush(input string name);
    for (int unsigned i = 0; i < LAT + 1; i++) step(name, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    held     = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{8'h09, 8'h08, 16'h0048};
    vecs[1] = '{8'h20, 8'h20, 16'h0400};
    vecs[2] = '{8'hDA, 8'hAD, 16'h9352};
    vecs[3] = '{8'hBE, 8'hEF, 16'hB162};
    vecs[4] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[5] = '{8'h00, 8'hA5, 16'h0000};
    vecs[6] = '{8'h01, 8'h7E, 16'h007E};
    vecs[7] = '{8'h80, 8'h02, 16'h0100};

    // Reset held two cycles with valid operands present
    step("reset0", 1'b1, 1'b1, 8'h55, 8'h55, 16'h1C39);
    step("reset1", 1'b1, 1'b1, 8'h55, 8'h55, 16'h1C39);
    flush("post_reset_idle");

    for (int unsigned i = 0; i < 8; i++) begin
      step("table", 1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    flush("table_drain");

    // Gapped valids: 1,0,1
    step("gap_a", 1'b0, 1'b1, 8'd3, 8'd5, 16'h000F);
    step("gap_idle", 1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    step("gap_b", 1'b0, 1'b1, 8'd7, 8'd11, 16'h004D);
    flush("gap_drain");

    // Reset the cycle after a pair is accepted
    step("mid_pair", 1'b0, 1'b1, 8'hDA, 8'hAD, 16'h9352);
    step("mid_rst", 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000);
    flush("mid_after");

    // Exhaustive stream, one pair per cycle
    for (int unsigned x = 0; x < 256; x++) begin
      for (int unsigned y = 0; y < 256; y++) begin
        step("exhaustive", 1'b0, 1'b1, x[7:0], y[7:0], 16'(x * y));
      end
    end
    flush("exhaustive_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
